// File: rtl/proc_pkg.sv
// Shared definitions for the 1x8 serial-to-parallel demultiplexer.
//   SLOT_W / SLOTS : slot counter width and slot count
//   state_e        : FSM state encoding (StParity only used when
//                    DEMUX_1X8_DESER_PARITY_EN is defined)
//   bit_pos()      : maps a slot index to an assembly-register bit position
package proc_pkg;

    localparam int unsigned SLOT_W = 3;
    localparam int unsigned SLOTS  = 8;

    typedef enum logic {
        StCollect = 1'b0,
        StParity  = 1'b1
    } state_e;

    // MSB-first streams fill the byte from bit 7 downwards.
    function automatic logic [SLOT_W-1:0] bit_pos(input logic [SLOT_W-1:0] slot,
                                                  input logic              msb_first);
        return msb_first ? (3'd7 - slot) : slot;
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// One-hot slot write-enable decoder (structural mirror of the 8:1 select).
//   en_i     : accept strobe; all enables low when deasserted
//   sel_i    : bit position to write
//   onehot_o : per-bit write enables of the assembly register
module decoder_3x8
    import proc_pkg::*;
(
    input  logic              en_i,
    input  logic [SLOT_W-1:0] sel_i,
    output logic [SLOTS-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel demultiplexer with a one-entry valid/ready holding register.
//   clk, reset             : clock, synchronous active-high reset
//   bit_in/valid/ready     : serial input handshake; frame_start marks first bit
//   word_out/valid/ready   : assembled byte output handshake
//   slot_sel               : current slot counter (observe only)
//   frame_drop             : one-cycle pulse when a partial byte is discarded
//   parity_err             : only with DEMUX_1X8_DESER_PARITY_EN; even-parity error
//                            flag registered alongside word_out
module demux_1x8_deser
    import proc_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned SLOTS     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       frame_start,
    output logic [7:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic [2:0] slot_sel,
`ifdef DEMUX_1X8_DESER_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_drop
);

    localparam int unsigned LastSlotI = SLOTS - 1;
    localparam logic [2:0]  LastSlot  = LastSlotI[2:0];

    state_e     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] asm_q, asm_d;
    logic [7:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       drop_q, drop_d;
`ifdef DEMUX_1X8_DESER_PARITY_EN
    logic       perr_q, perr_d;
`endif

    logic       stall, accept, pop, dec_en;
    logic [2:0] wr_pos;
    logic [7:0] wr_en, asm_base, asm_wr;

    // frame_start never stalls: it opens a new byte rather than completing one.
`ifdef DEMUX_1X8_DESER_PARITY_EN
    assign stall = valid_q && !word_ready && (state_q == StParity) && !(bit_valid && frame_start);
`else
    assign stall = valid_q && !word_ready && (slot_q == LastSlot) && !(bit_valid && frame_start);
`endif
    assign bit_ready = !stall;
    assign accept    = bit_valid && !stall;
    assign pop       = valid_q && word_ready;

    // The parity bit is not a data bit, so it must not hit the assembly register.
    assign dec_en = accept && ((state_q == StCollect) || frame_start);
    assign wr_pos = bit_pos(frame_start ? 3'd0 : slot_q, MSB_FIRST);

    decoder_3x8 u_dec (
        .en_i     (dec_en),
        .sel_i    (wr_pos),
        .onehot_o (wr_en)
    );

    assign asm_base = frame_start ? 8'h00 : asm_q;
    assign asm_wr   = (asm_base & ~wr_en) | (wr_en & {8{bit_in}});

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        asm_d   = asm_q;
        word_d  = word_q;
        valid_d = valid_q && !pop;
        drop_d  = 1'b0;
`ifdef DEMUX_1X8_DESER_PARITY_EN
        perr_d  = perr_q;
`endif
        if (accept) begin
            if (frame_start) begin
                asm_d   = asm_wr;
                slot_d  = 3'd1;
                state_d = StCollect;
                drop_d  = (slot_q != 3'd0) || (state_q == StParity);
`ifdef DEMUX_1X8_DESER_PARITY_EN
            end else if (state_q == StParity) begin
                word_d  = asm_q;
                perr_d  = (^asm_q) ^ bit_in;
                valid_d = 1'b1;
                asm_d   = 8'h00;
                state_d = StCollect;
`endif
            end else begin
                asm_d  = asm_wr;
                slot_d = slot_q + 3'd1;
                if (slot_q == LastSlot) begin
`ifdef DEMUX_1X8_DESER_PARITY_EN
                    state_d = StParity;
`else
                    word_d  = asm_wr;
                    valid_d = 1'b1;
                    asm_d   = 8'h00;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
            slot_q  <= 3'd0;
            asm_q   <= 8'h00;
            word_q  <= 8'h00;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
`ifdef DEMUX_1X8_DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
`ifdef DEMUX_1X8_DESER_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign slot_sel   = slot_q;
    assign frame_drop = drop_q;
`ifdef DEMUX_1X8_DESER_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Self-checking bench for demux_1x8_deser: an LSB-first and an MSB-first instance share
// the same stimulus and are compared against a bit-list reference model.
module tb_demux_1x8_deser;

    logic       clk = 1'b0;
    logic       reset, bit_in, bit_valid, frame_start, word_ready;
    logic       rdy_l, rdy_m, wv_l, wv_m, fd_l, fd_m;
    logic [7:0] wo_l, wo_m;
    logic [2:0] ss_l, ss_m;
`ifdef DEMUX_1X8_DESER_PARITY_EN
    logic       pe_l, pe_m;
`endif

    always #5 clk = ~clk;

    demux_1x8_deser #(.MSB_FIRST(1'b0), .SLOTS(8)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (rdy_l),
        .frame_start (frame_start),
        .word_out    (wo_l),
        .word_valid  (wv_l),
        .word_ready  (word_ready),
        .slot_sel    (ss_l),
`ifdef DEMUX_1X8_DESER_PARITY_EN
        .parity_err  (pe_l),
`endif
        .frame_drop  (fd_l)
    );

    demux_1x8_deser #(.MSB_FIRST(1'b1), .SLOTS(8)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (rdy_m),
        .frame_start (frame_start),
        .word_out    (wo_m),
        .word_valid  (wv_m),
        .word_ready  (word_ready),
        .slot_sel    (ss_m),
`ifdef DEMUX_1X8_DESER_PARITY_EN
        .parity_err  (pe_m),
`endif
        .frame_drop  (fd_m)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: list of data bits received for the current byte, plus the holder.
    bit         q_bits[$];
    bit         m_wait;     // eight data bits held, parity bit pending
    bit         m_valid;
    logic [7:0] m_word_l, m_word_m;
    bit         m_drop;
    bit         m_perr;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input bit pbit);
        logic [7:0] bl, bm;
        bl = 8'h00;
        bm = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bl[i]     = q_bits[i];
            bm[7 - i] = q_bits[i];
        end
        m_word_l = bl;
        m_word_m = bm;
        m_perr   = (^bl) ^ pbit;
        m_valid  = 1'b1;
        q_bits.delete();
        m_wait   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] exp_slot;
        exp_slot = m_wait ? 3'd0 : 3'(q_bits.size());
        check({tag, ":valid_l"}, {7'd0, wv_l}, {7'd0, m_valid});
        check({tag, ":valid_m"}, {7'd0, wv_m}, {7'd0, m_valid});
        check({tag, ":word_l"}, wo_l, m_word_l);
        check({tag, ":word_m"}, wo_m, m_word_m);
        check({tag, ":slot_l"}, {5'd0, ss_l}, {5'd0, exp_slot});
        check({tag, ":slot_m"}, {5'd0, ss_m}, {5'd0, exp_slot});
        check({tag, ":drop_l"}, {7'd0, fd_l}, {7'd0, m_drop});
        check({tag, ":drop_m"}, {7'd0, fd_m}, {7'd0, m_drop});
`ifdef DEMUX_1X8_DESER_PARITY_EN
        if (m_valid) begin
            check({tag, ":perr_l"}, {7'd0, pe_l}, {7'd0, m_perr});
            check({tag, ":perr_m"}, {7'd0, pe_m}, {7'd0, m_perr});
        end
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; word_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        q_bits.delete();
        m_wait = 1'b0; m_valid = 1'b0; m_word_l = 8'h00; m_word_m = 8'h00;
        m_drop = 1'b0; m_perr = 1'b0;
        check_outputs("reset");
        check("reset:ready_l", {7'd0, rdy_l}, 8'd1);
        check("reset:ready_m", {7'd0, rdy_m}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input bit bv, input bit bi, input bit fs, input bit wr);
        bit exp_rdy, acc, at_end;
        @(negedge clk);
        bit_valid = bv; bit_in = bi; frame_start = fs; word_ready = wr;
        #1;
`ifdef DEMUX_1X8_DESER_PARITY_EN
        at_end = m_wait;
`else
        at_end = (q_bits.size() == 7);
`endif
        exp_rdy = !(m_valid && !wr && at_end && !(bv && fs));
        check("bit_ready_l", {7'd0, rdy_l}, {7'd0, exp_rdy});
        check("bit_ready_m", {7'd0, rdy_m}, {7'd0, exp_rdy});
        acc = bv && exp_rdy;
        @(posedge clk);
        #1;
        m_drop = 1'b0;
        if (m_valid && wr) m_valid = 1'b0;
        if (acc) begin
            if (fs) begin
                m_drop = (q_bits.size() != 0) || m_wait;
                q_bits.delete();
                q_bits.push_back(bi);
                m_wait = 1'b0;
            end else if (m_wait) begin
                load_word(bi);
            end else begin
                q_bits.push_back(bi);
                if (q_bits.size() == 8) begin
`ifdef DEMUX_1X8_DESER_PARITY_EN
                    m_wait = 1'b1;
`else
                    load_word(1'b0);
`endif
                end
            end
        end
        check_outputs("step");
    endtask

    // Sends one byte LSB-index-first from data[0]; parity bit appended when enabled.
    task automatic send_byte(input logic [7:0] data, input bit pbit, input bit wr);
        for (int i = 0; i < 8; i++) step(1'b1, data[i], 1'b0, wr);
`ifdef DEMUX_1X8_DESER_PARITY_EN
        step(1'b1, pbit, 1'b0, wr);
`else
        if (pbit) vectors = vectors + 0;
`endif
    endtask

    initial begin
        apply_reset();

        // Stream 1,0,1,1,0,0,1,0 -> 4D (LSB-first) / B2 (MSB-first).
        send_byte(8'b0100_1101, 1'b0, 1'b1);
        check("byte_4d_l", wo_l, 8'h4D);
        check("byte_b2_m", wo_m, 8'hB2);
        check("byte_4d_slot", {5'd0, ss_l}, 8'd0);

        // Back-to-back FF then 00 with consumer stalled; pop coincides with completion.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef DEMUX_1X8_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_ff", wo_l, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("reload_00", wo_l, 8'h00);
        check("reload_valid", {7'd0, wv_l}, 8'd1);

        // Partial byte dropped by frame_start.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("drop_pulse", {7'd0, fd_l}, 8'd1);
        check("drop_slot", {5'd0, ss_l}, 8'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DEMUX_1X8_DESER_PARITY_EN
        step(1'b1, 1'b1, 1'b0, 1'b1);
`endif
        check("frame_01_l", wo_l, 8'h01);
        check("frame_01_m", wo_m, 8'h80);

`ifdef DEMUX_1X8_DESER_PARITY_EN
        send_byte(8'h4D, 1'b1, 1'b1);
        check("perr_set", {7'd0, pe_l}, 8'd1);
        send_byte(8'h4D, 1'b0, 1'b1);
        check("perr_clr", {7'd0, pe_l}, 8'd0);
`endif

        // Reset mid-byte with a word held.
        send_byte(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        apply_reset();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 16) == 0,
                 ($urandom % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
